// File: rtl/bt656_tx_stream.sv
// BT.656 / 10-bit ITU-R 656 transmitter: 4:2:2 words in, byte slots with EAV/SAV codes and blanking out.
// Define BT656_TX_PATTERN_EN to add i_PatternEn and the built-in luma ramp test pattern.
module bt656_tx_stream #(
    parameter int DATA_W      = 8,
    parameter int HACT_BYTES  = 1440,
    parameter int HBLK_BYTES  = 276,
    parameter int VACT_F1     = 240,
    parameter int VBLK_F1_TOP = 18,
    parameter int VBLK_F1_BOT = 4,
    parameter int VACT_F2     = 240,
    parameter int VBLK_F2_TOP = 18,
    parameter int VBLK_F2_BOT = 5
) (
    input  logic                i_SysClock,
    input  logic                i_ResetN,
    input  logic                i_PixelEn,
    input  logic                i_TxEnable,
    input  logic                i_InterlaceMode,
    input  logic                i_FirstField,
    input  logic                i_PixValid,
    output logic                o_PixReady,
    input  logic [4*DATA_W-1:0] i_PixData,
    input  logic                i_UnderflowClr,
`ifdef BT656_TX_PATTERN_EN
    input  logic                i_PatternEn,
`endif
    output logic [DATA_W-1:0]   o_Data,
    output logic                o_DataValid,
    output logic                o_Hsignal,
    output logic                o_Vsignal,
    output logic                o_Fsignal,
    output logic                o_Underflow
);

    localparam int LINE_BYTES = HBLK_BYTES + HACT_BYTES;
    localparam int F1_LINES   = VBLK_F1_TOP + VACT_F1 + VBLK_F1_BOT;
    localparam int F2_LINES   = VBLK_F2_TOP + VACT_F2 + VBLK_F2_BOT;
    localparam int MAX_LINES  = (F1_LINES > F2_LINES) ? F1_LINES : F2_LINES;
    localparam int HW         = $clog2(LINE_BYTES);
    localparam int LW         = $clog2(MAX_LINES + 1);
    localparam int SH         = DATA_W - 8;

    localparam logic [HW-1:0] H_LAST    = HW'(LINE_BYTES - 1);
    localparam logic [HW-1:0] H_EAV_END = HW'(4);
    localparam logic [HW-1:0] H_SAV     = HW'(HBLK_BYTES - 4);
    localparam logic [HW-1:0] H_ACT     = HW'(HBLK_BYTES);

    localparam logic [LW-1:0] F1_TOP_L  = LW'(VBLK_F1_TOP);
    localparam logic [LW-1:0] F1_AEND_L = LW'(VBLK_F1_TOP + VACT_F1);
    localparam logic [LW-1:0] F1_LAST_L = LW'(F1_LINES - 1);
    localparam logic [LW-1:0] F2_TOP_L  = LW'(VBLK_F2_TOP);
    localparam logic [LW-1:0] F2_AEND_L = LW'(VBLK_F2_TOP + VACT_F2);
    localparam logic [LW-1:0] F2_LAST_L = LW'(F2_LINES - 1);

    localparam logic [DATA_W-1:0]   C_C        = DATA_W'(8'h80) << SH;
    localparam logic [DATA_W-1:0]   C_Y        = DATA_W'(8'h10) << SH;
    localparam logic [4*DATA_W-1:0] BLANK_WORD = {C_C, C_Y, C_C, C_Y};

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t state_q, state_d;

    logic [HW-1:0]       h_q;
    logic [LW-1:0]       line_q;
    logic                f_q;
    logic                ilace_q;
    logic [4*DATA_W-1:0] hold_q;
    logic                hold_full_q;
    logic [4*DATA_W-1:0] shift_q;

    logic [LW-1:0]       top_l, aend_l, last_l;
    logic                v_bit, h_bit;
    logic [1:0]          k;
    logic                in_code, in_act, grp_first, field_end;
    logic                grp_strobe, pat_on, unload, uf_set, take;
    logic [7:0]          xy8;
    logic [DATA_W-1:0]   xy_w, slot_data;
    logic [4*DATA_W-1:0] grp_word;

    // Field 2 geometry applies only to the F=1 field of an interlaced raster.
    always_comb begin
        top_l  = F1_TOP_L;
        aend_l = F1_AEND_L;
        last_l = F1_LAST_L;
        if (ilace_q && f_q) begin
            top_l  = F2_TOP_L;
            aend_l = F2_AEND_L;
            last_l = F2_LAST_L;
        end
    end

    assign v_bit     = (line_q < top_l) || (line_q >= aend_l);
    assign h_bit     = (h_q < H_SAV);
    assign k         = h_q[1:0];
    assign in_code   = (h_q < H_EAV_END) || ((h_q >= H_SAV) && (h_q < H_ACT));
    assign in_act    = (h_q >= H_ACT);
    assign grp_first = in_act && !v_bit && (k == 2'd0);
    assign field_end = (h_q == H_LAST) && (line_q == last_l);
    assign xy8       = {1'b1, f_q, v_bit, h_bit, v_bit ^ h_bit, f_q ^ h_bit, f_q ^ v_bit, f_q ^ v_bit ^ h_bit};
    assign xy_w      = DATA_W'(xy8) << SH;

    // Strict valid/ready: a word transfers on any clock with i_PixValid && o_PixReady and valid
    // must hold until then. Ready drops while the hold register is full and on every group-unload strobe.
    assign grp_strobe = i_PixelEn && (state_q == ST_RUN) && grp_first;
    assign unload     = grp_strobe && hold_full_q && !pat_on;
    assign uf_set     = grp_strobe && !hold_full_q && !pat_on;
    assign o_PixReady = !hold_full_q && !grp_strobe && !pat_on;
    assign take       = i_PixValid && o_PixReady;

`ifdef BT656_TX_PATTERN_EN
    logic [HW-1:0]     act_off;
    logic [DATA_W-1:0] pat_y;
    assign act_off = h_q - H_ACT;
    assign pat_y   = DATA_W'(8'(act_off >> 2)) << SH;
    assign pat_on  = i_PatternEn;
`else
    assign pat_on  = 1'b0;
`endif

    always_comb begin
        grp_word = hold_full_q ? hold_q : BLANK_WORD;
`ifdef BT656_TX_PATTERN_EN
        if (i_PatternEn) grp_word = {C_C, pat_y, C_C, pat_y};
`endif
    end

    // Slot 0 of a group comes straight from the word being unloaded; slots 1..3 from the shift copy.
    always_comb begin
        slot_data = h_q[0] ? C_Y : C_C;
        if (in_code) begin
            case (k)
                2'd0:    slot_data = '1;
                2'd3:    slot_data = xy_w;
                default: slot_data = '0;
            endcase
        end else if (in_act && !v_bit) begin
            case (k)
                2'd0:    slot_data = grp_word[4*DATA_W-1 -: DATA_W];
                2'd1:    slot_data = shift_q[3*DATA_W-1 -: DATA_W];
                2'd2:    slot_data = shift_q[2*DATA_W-1 -: DATA_W];
                default: slot_data = shift_q[DATA_W-1:0];
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_PixelEn && i_TxEnable) state_d = ST_RUN;
            ST_RUN:  if (i_PixelEn && field_end && !i_TxEnable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state_q     <= ST_IDLE;
            h_q         <= '0;
            line_q      <= '0;
            f_q         <= 1'b0;
            ilace_q     <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            o_Data      <= '0;
            o_DataValid <= 1'b0;
            o_Hsignal   <= 1'b1;
            o_Vsignal   <= 1'b1;
            o_Fsignal   <= 1'b0;
            o_Underflow <= 1'b0;
        end else begin
            state_q     <= state_d;
            o_DataValid <= i_PixelEn;
            if (i_PixelEn) begin
                if (state_q == ST_RUN) begin
                    o_Data    <= slot_data;
                    o_Hsignal <= h_bit;
                    o_Vsignal <= v_bit;
                    o_Fsignal <= f_q;
                    if (grp_strobe) shift_q <= grp_word;
                    if (h_q == H_LAST) begin
                        h_q <= '0;
                        if (line_q == last_l) begin
                            line_q <= '0;
                            f_q    <= f_q ^ ilace_q;
                        end else begin
                            line_q <= line_q + 1'b1;
                        end
                    end else begin
                        h_q <= h_q + 1'b1;
                    end
                end else begin
                    o_Data    <= '0;
                    o_Hsignal <= 1'b1;
                    o_Vsignal <= 1'b1;
                    o_Fsignal <= 1'b0;
                    if (i_TxEnable) begin
                        h_q     <= '0;
                        line_q  <= '0;
                        ilace_q <= i_InterlaceMode;
                        f_q     <= i_InterlaceMode & i_FirstField;
                    end
                end
            end
            if (unload) begin
                hold_full_q <= 1'b0;
            end else if (take) begin
                hold_q      <= i_PixData;
                hold_full_q <= 1'b1;
            end
            if (uf_set) begin
                o_Underflow <= 1'b1;
            end else if (i_UnderflowClr) begin
                o_Underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bt656_tx_stream.sv
// Scoreboard bench for bt656_tx_stream: 8-bit and 10-bit instances share stimulus and are
// compared against a reference model that walks the field as a flat slot position.
module tb_bt656_tx_stream;

    localparam int HACT   = 16;
    localparam int HBLK   = 12;
    localparam int LINE   = HACT + HBLK;
    localparam int F1_ACT = 4;
    localparam int F1_TOP = 2;
    localparam int F1_BOT = 1;
    localparam int F2_ACT = 4;
    localparam int F2_TOP = 2;
    localparam int F2_BOT = 2;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        pix_en = 1'b0, tx_en = 1'b0, ilace = 1'b0, first_f = 1'b0;
    logic        pix_valid = 1'b0, uf_clr = 1'b0;
    logic [31:0] pix_data8 = '0;
    logic [39:0] pix_data10 = '0;

    logic       rdy8, dv8, hs8, vs8, fs8, uf8;
    logic [7:0] data8;
    logic       rdy10, dv10, hs10, vs10, fs10, uf10;
    logic [9:0] data10;

    bt656_tx_stream #(
        .DATA_W(8), .HACT_BYTES(HACT), .HBLK_BYTES(HBLK),
        .VACT_F1(F1_ACT), .VBLK_F1_TOP(F1_TOP), .VBLK_F1_BOT(F1_BOT),
        .VACT_F2(F2_ACT), .VBLK_F2_TOP(F2_TOP), .VBLK_F2_BOT(F2_BOT)
    ) u_dut8 (
        .i_SysClock(clk), .i_ResetN(rst_n), .i_PixelEn(pix_en), .i_TxEnable(tx_en),
        .i_InterlaceMode(ilace), .i_FirstField(first_f), .i_PixValid(pix_valid),
        .o_PixReady(rdy8), .i_PixData(pix_data8), .i_UnderflowClr(uf_clr),
`ifdef BT656_TX_PATTERN_EN
        .i_PatternEn(1'b0),
`endif
        .o_Data(data8), .o_DataValid(dv8), .o_Hsignal(hs8), .o_Vsignal(vs8),
        .o_Fsignal(fs8), .o_Underflow(uf8)
    );

    bt656_tx_stream #(
        .DATA_W(10), .HACT_BYTES(HACT), .HBLK_BYTES(HBLK),
        .VACT_F1(F1_ACT), .VBLK_F1_TOP(F1_TOP), .VBLK_F1_BOT(F1_BOT),
        .VACT_F2(F2_ACT), .VBLK_F2_TOP(F2_TOP), .VBLK_F2_BOT(F2_BOT)
    ) u_dut10 (
        .i_SysClock(clk), .i_ResetN(rst_n), .i_PixelEn(pix_en), .i_TxEnable(tx_en),
        .i_InterlaceMode(ilace), .i_FirstField(first_f), .i_PixValid(pix_valid),
        .o_PixReady(rdy10), .i_PixData(pix_data10), .i_UnderflowClr(uf_clr),
`ifdef BT656_TX_PATTERN_EN
        .i_PatternEn(1'b0),
`endif
        .o_Data(data10), .o_DataValid(dv10), .o_Hsignal(hs10), .o_Vsignal(vs10),
        .o_Fsignal(fs10), .o_Underflow(uf10)
    );

    // Scoreboard state: expected {data, H, V, F} per strobe
    logic [10:0] exp8_q[$];
    logic [12:0] exp10_q[$];
    logic [31:0] hold8_q[$];
    logic [39:0] hold10_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          m_run = 1'b0, m_ilace = 1'b0, m_f = 1'b0, m_uf = 1'b0, m_prev_en = 1'b0;
    int          m_pos = 0;
    logic [31:0] grp8 = '0;
    logic [39:0] grp10 = '0;

    // Producer and control state
    bit          cur_valid = 1'b0;
    logic [31:0] cur8 = '0;
    logic [39:0] cur10 = '0;
    int          valid_pct = 90;
    bit          want_tx = 1'b0, want_il = 1'b0, want_ff = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] code_byte(input int h, input bit v, input bit f, input bit ten);
        bit hb;
        int xy;
        hb = (h < HBLK - 4);
        xy = 128 + 64 * int'(f) + 32 * int'(v) + 16 * int'(hb) + 8 * int'(v ^ hb)
             + 4 * int'(f ^ hb) + 2 * int'(f ^ v) + int'(f ^ v ^ hb);
        case (h % 4)
            0:       return ten ? 10'h3FF : 10'h0FF;
            3:       return ten ? 10'(xy * 4) : 10'(xy);
            default: return 10'h000;
        endcase
    endfunction

    // Evaluates the coming rising edge: checks the pre-edge outputs, then predicts the edge.
    task automatic model_edge();
        int top, vact, lines, h, ln, k;
        bit v, hb, grp, ready, set_now;
        logic [9:0] b8, b10;
        if (m_ilace && m_f) begin
            top = F2_TOP; vact = F2_ACT; lines = F2_TOP + F2_ACT + F2_BOT;
        end else begin
            top = F1_TOP; vact = F1_ACT; lines = F1_TOP + F1_ACT + F1_BOT;
        end
        h   = m_pos % LINE;
        ln  = m_pos / LINE;
        v   = (ln < top) || (ln >= top + vact);
        hb  = (h < HBLK - 4);
        grp = pix_en && m_run && (h >= HBLK) && !v && ((h - HBLK) % 4 == 0);
        ready   = (hold8_q.size() == 0) && !grp;
        set_now = 1'b0;
        check("pix_ready8", 64'(rdy8), 64'(ready));
        check("pix_ready10", 64'(rdy10), 64'(ready));
        check("underflow8", 64'(uf8), 64'(m_uf));
        check("underflow10", 64'(uf10), 64'(m_uf));
        check("data_valid8", 64'(dv8), 64'(m_prev_en));
        check("data_valid10", 64'(dv10), 64'(m_prev_en));
        m_prev_en = pix_en;
        if (pix_en) begin
            if (!m_run) begin
                exp8_q.push_back({8'h00, 3'b110});
                exp10_q.push_back({10'h000, 3'b110});
                if (tx_en) begin
                    m_run = 1'b1; m_pos = 0; m_ilace = ilace; m_f = ilace & first_f;
                end
            end else begin
                if (h < 4 || (h >= HBLK - 4 && h < HBLK)) begin
                    b8  = code_byte(h, v, m_f, 1'b0);
                    b10 = code_byte(h, v, m_f, 1'b1);
                end else if (h >= HBLK && !v) begin
                    k = (h - HBLK) % 4;
                    if (k == 0) begin
                        if (hold8_q.size() > 0) begin
                            grp8  = hold8_q.pop_front();
                            grp10 = hold10_q.pop_front();
                        end else begin
                            grp8    = 32'h8010_8010;
                            grp10   = {10'h200, 10'h040, 10'h200, 10'h040};
                            m_uf    = 1'b1;
                            set_now = 1'b1;
                        end
                    end
                    b8  = {2'b00, grp8[8*(3-k) +: 8]};
                    b10 = grp10[10*(3-k) +: 10];
                end else begin
                    b8  = (h % 2 == 0) ? 10'h080 : 10'h010;
                    b10 = b8 << 2;
                end
                exp8_q.push_back({b8[7:0], hb, v, m_f});
                exp10_q.push_back({b10, hb, v, m_f});
                m_pos++;
                if (m_pos == lines * LINE) begin
                    m_pos = 0;
                    m_f   = m_f ^ m_ilace;
                    if (!tx_en) m_run = 1'b0;
                end
            end
        end
        if (!set_now && uf_clr) m_uf = 1'b0;
        if (cur_valid && ready) begin
            hold8_q.push_back(cur8);
            hold10_q.push_back(cur10);
            cur_valid = 1'b0;
        end
    endtask

    // Driver: one clock of stimulus, inputs changed on the falling edge
    task automatic cycle(input bit en);
        @(negedge clk);
        pix_en  = en;
        tx_en   = want_tx;
        ilace   = want_il;
        first_f = want_ff;
        uf_clr  = ($urandom_range(0, 63) == 0);
        if (!cur_valid && ($urandom_range(0, 99) < valid_pct)) begin
            cur8          = $urandom;
            cur10[31:0]   = $urandom;
            cur10[39:32]  = 8'($urandom);
            cur_valid     = 1'b1;
        end
        pix_valid  = cur_valid;
        pix_data8  = cur8;
        pix_data10 = cur10;
        #1;
        model_edge();
    endtask

    task automatic check_reset_outputs();
        check("rst_data8", 64'(data8), 64'h0);
        check("rst_valid8", 64'(dv8), 64'h0);
        check("rst_hvf8", 64'({hs8, vs8, fs8}), 64'b110);
        check("rst_ready8", 64'(rdy8), 64'h1);
        check("rst_underflow8", 64'(uf8), 64'h0);
        check("rst_data10", 64'(data10), 64'h0);
        check("rst_valid10", 64'(dv10), 64'h0);
        check("rst_hvf10", 64'({hs10, vs10, fs10}), 64'b110);
        check("rst_ready10", 64'(rdy10), 64'h1);
        check("rst_underflow10", 64'(uf10), 64'h0);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp8_q.delete(); exp10_q.delete();
        hold8_q.delete(); hold10_q.delete();
        m_run = 1'b0; m_uf = 1'b0; m_prev_en = 1'b0; m_pos = 0; m_f = 1'b0;
        pix_en = 1'b0; pix_valid = 1'b0; uf_clr = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: pops one expectation for every registered strobe result
    logic [10:0] e8;
    logic [12:0] e10;
    always @(negedge clk) begin
        if (rst_n && dv8) begin
            if (exp8_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL out8: output 0x%0h with no expected entry at %0t", data8, $time);
            end else begin
                e8 = exp8_q.pop_front();
                check("out8 {data,H,V,F}", 64'({data8, hs8, vs8, fs8}), 64'(e8));
            end
        end
        if (rst_n && dv10) begin
            if (exp10_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL out10: output 0x%0h with no expected entry at %0t", data10, $time);
            end else begin
                e10 = exp10_q.pop_front();
                check("out10 {data,H,V,F}", 64'({data10, hs10, vs10, fs10}), 64'(e10));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs();
        #3;
        rst_n = 1'b1;

        // Interlaced, F=0 first, continuous strobe, two full frames
        want_tx = 1'b1; want_il = 1'b1; want_ff = 1'b0;
        repeat (2 * 15 * LINE + 40) cycle(1'b1);

        // Upstream stall to force underflowed groups
        valid_pct = 0;
        repeat (60) cycle(1'b1);
        valid_pct = 90;
        repeat (120) cycle(1'b1);

        // Stop at field end, then progressive with F requested 1 and a sparse strobe
        want_tx = 1'b0;
        for (int i = 0; i < 600 && m_run; i++) cycle(1'b1);
        want_il = 1'b0; want_ff = 1'b1; want_tx = 1'b1;
        repeat (1800) cycle(bit'($urandom_range(0, 3) == 0));

        // Drop the enable mid-field: the field completes, then idle output
        repeat (100) cycle(1'b1);
        want_tx = 1'b0;
        repeat (300) cycle(1'b1);
        repeat (20) cycle(1'b1);

        // Interlaced starting on F=1, then reset mid-line
        want_il = 1'b1; want_ff = 1'b1; want_tx = 1'b1;
        repeat (150) cycle(1'b1);
        reset_mid();
        repeat (120) cycle(bit'($urandom_range(0, 1) == 1));

        want_tx = 1'b0;
        repeat (6) cycle(1'b0);
        check("exp8_q drained", 64'(exp8_q.size()), 64'h0);
        check("exp10_q drained", 64'(exp10_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
